// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared constants and helpers for the RV32M multiply/divide unit.
//   - M-op alucode values (the only codes the unit acts on) plus ALU_ADD
//   - MULSTALL/DIVSTALL: start-to-done cycle counts of a normal operation
//   - mdu_state_t: unit FSM states
//   - decode helpers that classify an alucode
package muldiv_unit_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_MUL    = 5'd20;
  localparam logic [4:0] ALU_MULH   = 5'd21;
  localparam logic [4:0] ALU_MULHSU = 5'd22;
  localparam logic [4:0] ALU_MULHU  = 5'd23;
  localparam logic [4:0] ALU_DIV    = 5'd24;
  localparam logic [4:0] ALU_DIVU   = 5'd25;
  localparam logic [4:0] ALU_REM    = 5'd26;
  localparam logic [4:0] ALU_REMU   = 5'd27;

  localparam int unsigned MULSTALL = 34;
  localparam int unsigned DIVSTALL = 34;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } mdu_state_t;

  function automatic logic op_is_div(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic op_is_mul(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
  endfunction

  function automatic logic op_is_m(input logic [4:0] op);
    return op_is_mul(op) || op_is_div(op);
  endfunction

  function automatic logic op_is_rem(input logic [4:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // rs1 is treated as signed
  function automatic logic op_a_signed(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
           (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  // rs2 is treated as signed
  function automatic logic op_b_signed(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: execute-stage request/response bundle of the multiply/divide unit.
//   master (execute stage): drives start, alucode, op1, op2, flush; sees busy, done, result
//   slave  (muldiv_unit)  : the reverse
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [4:0]      alucode;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, alucode, op1, op2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, alucode, op1, op2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit_div_restoring_step.sv
// div_restoring_step: one combinational restoring-division iteration.
//   rem_in       : partial remainder (always < divisor)
//   divisor      : divisor magnitude
//   dividend_bit : next dividend bit shifted into the remainder
//   rem_out      : updated partial remainder
//   q_bit        : quotient bit produced by this iteration
module div_restoring_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);
  logic [XLEN:0] trial;

  always_comb begin
    trial = {rem_in, dividend_bit};
    q_bit = (trial >= {1'b0, divisor});
    // When the subtraction succeeds the true difference is below the divisor,
    // so a modular XLEN-bit subtract is exact.
    rem_out = q_bit ? (trial[XLEN-1:0] - divisor) : trial[XLEN-1:0];
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : muldiv_unit_if slave (start/alucode/op1/op2/flush in; busy/done/result out)
// Operands are reduced to magnitudes on start; a single 64-bit register is
// shifted once per cycle for 32 cycles (shift-add multiply or restoring
// divide), then the sign is applied in FIX and the result is registered on
// entry to DONE. Divide-by-zero and signed overflow go straight to DONE.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  mdu_state_t state, state_nx;

  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opb;      // multiplicand or divisor magnitude
  logic [4:0]        op_q;
  logic              neg_lo;   // product / quotient negation
  logic              neg_hi;   // remainder negation
  logic [XLEN-1:0]   result_q;

  // Start decode
  logic            accept;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   step_rem;
  logic              step_q;
  logic [2*XLEN-1:0] acc_nx;

  // Sign fix-up
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    accept = (state == S_IDLE) && bus.start && op_is_m(bus.alucode) && !bus.flush;
    sign_a = op_a_signed(bus.alucode) && bus.op1[XLEN-1];
    sign_b = op_b_signed(bus.alucode) && bus.op2[XLEN-1];
    // Magnitude of the most negative value wraps to 1<<(XLEN-1), which is
    // the correct unsigned magnitude, so XLEN bits suffice.
    mag_a = sign_a ? (~bus.op1 + 1'b1) : bus.op1;
    mag_b = sign_b ? (~bus.op2 + 1'b1) : bus.op2;

    div_zero = op_is_div(bus.alucode) && (bus.op2 == '0);
    div_ovf  = ((bus.alucode == ALU_DIV) || (bus.alucode == ALU_REM)) &&
               (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2 == '1);
    special  = div_zero || div_ovf;

    if (div_zero) special_res = op_is_rem(bus.alucode) ? bus.op1 : '1;
    else          special_res = op_is_rem(bus.alucode) ? '0 : bus.op1;
  end

  div_restoring_step #(.XLEN(XLEN)) u_step (
    .rem_in       (acc[2*XLEN-1:XLEN]),
    .divisor      (opb),
    .dividend_bit (acc[XLEN-1]),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    if (op_is_div(op_q)) acc_nx = {step_rem, acc[XLEN-2:0], step_q};
    else                 acc_nx = {mul_sum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod_fix = neg_lo ? (~acc + 1'b1) : acc;
    quot_fix = neg_lo ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix  = neg_hi ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (op_q)
      ALU_MUL:                          fix_res = prod_fix[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:                fix_res = quot_fix;
      default:                          fix_res = rem_fix;
    endcase
  end

  // FSM
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = special ? S_DONE : S_ITER;
      S_ITER: if (cnt == 6'd31) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if ((state != S_IDLE) && bus.flush) state_nx = S_IDLE;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      op_q     <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cnt    <= '0;
          op_q   <= bus.alucode;
          neg_lo <= sign_a ^ sign_b;
          neg_hi <= sign_a;
          if (op_is_div(bus.alucode)) begin
            acc <= {{XLEN{1'b0}}, mag_a};
            opb <= mag_b;
          end else begin
            acc <= {{XLEN{1'b0}}, mag_b};
            opb <= mag_a;
          end
          if (special) result_q <= special_res;
        end
        S_ITER: begin
          acc <= acc_nx;
          cnt <= cnt + 6'd1;
        end
        S_FIX: if (!bus.flush) result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: plain arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic signed [31:0] x, y;
    x = a;
    y = b;
    sa = (op == ALU_MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
    sb = (op == ALU_MULHU || op == ALU_MULHSU) ? {32'b0, b} : {{32{b[31]}}, b};
    p = sa * sb;
    case (op)
      ALU_MUL:                          return p[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  return p[63:32];
      ALU_DIV:  if (b == 0) return 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                else return x / y;
      ALU_REM:  if (b == 0) return a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                else return x % y;
      ALU_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic bit is_special(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op != ALU_DIV && op != ALU_DIVU && op != ALU_REM && op != ALU_REMU) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == ALU_DIV || op == ALU_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF;
  endfunction

  // Called at a negedge; the following posedge is cycle 0.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done, input string name);
    exp_t e;
    bus.start   = 1'b1;
    bus.alucode = op;
    bus.op1     = a;
    bus.op2     = b;
    if (expect_done) begin
      e.res  = ref_model(op, a, b);
      e.due  = cyc + (is_special(op, a, b) ? 1 : MULSTALL);
      e.name = name;
      sbq.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.op1   = $urandom;
    bus.op2   = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while ((bus.busy || sbq.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      check({name, " timeout"}, 32'd1, 32'd0);
      sbq.delete();
    end
  endtask

  // Monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, " result"}, bus.result, e.res);
        check({e.name, " done_cycle"}, cyc, e.due);
      end
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  mops[8];
    logic [31:0] prev;
    int unsigned n0;
    int          bad;

    mops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    reset = 1'b1;
    bus.start = 1'b0; bus.alucode = ALU_ADD; bus.op1 = '0; bus.op2 = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);

    // MUL 7 * -3 with busy profile over cycles 1..35
    n0 = cyc;
    issue(ALU_MUL, 32'd7, 32'hFFFFFFFD, 1'b1, "mul_7x-3");
    bad = 0;
    for (int k = 1; k <= 35; k++) begin
      if (bus.busy !== ((k <= 34) ? 1'b1 : 1'b0)) bad++;
      if (k < 35) @(negedge clk);
    end
    check("mul busy_profile_errors", bad, 32'd0);
    check("mul_7x-3 model", ref_model(ALU_MUL, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    wait_idle("mul_7x-3");

    issue(ALU_MULH,   32'h80000000, 32'h80000000, 1'b1, "mulh_min");     wait_idle("mulh_min");
    issue(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "mulhsu_ones");  wait_idle("mulhsu_ones");
    issue(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "mulhu_ones");   wait_idle("mulhu_ones");
    issue(ALU_DIV,    32'hFFFFFFF9, 32'd2, 1'b1, "div_-7_2");            wait_idle("div_-7_2");
    issue(ALU_REM,    32'hFFFFFFF9, 32'd2, 1'b1, "rem_-7_2");            wait_idle("rem_-7_2");
    issue(ALU_DIVU,   32'd100, 32'd7, 1'b1, "divu_100_7");               wait_idle("divu_100_7");
    issue(ALU_REMU,   32'd100, 32'd7, 1'b1, "remu_100_7");               wait_idle("remu_100_7");
    issue(ALU_DIVU,   32'd5, 32'd0, 1'b1, "divu_by0");
    check("divu_by0 busy_cycle1", {31'b0, bus.busy}, 32'd1);
    wait_idle("divu_by0");
    issue(ALU_REMU,   32'd5, 32'd0, 1'b1, "remu_by0");                   wait_idle("remu_by0");
    issue(ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf");      wait_idle("div_ovf");
    issue(ALU_REM,    32'h80000000, 32'hFFFFFFFF, 1'b1, "rem_ovf");      wait_idle("rem_ovf");

    // Non-M alucode is ignored
    prev = bus.result;
    issue(ALU_ADD, 32'd1, 32'd2, 1'b0, "add");
    check("add busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    check("add busy_later", {31'b0, bus.busy}, 32'd0);
    check("add result_held", bus.result, prev);

    // start together with flush in IDLE is dropped
    bus.flush = 1'b1;
    issue(ALU_DIVU, 32'd9, 32'd3, 1'b0, "start_flush");
    bus.flush = 1'b0;
    check("start_flush busy", {31'b0, bus.busy}, 32'd0);

    // Flush in cycle 10 of a MUL, new start in cycle 11
    prev = bus.result;
    n0 = cyc;
    issue(ALU_MUL, 32'h12345, 32'h6789, 1'b0, "mul_flushed");
    while (cyc < n0 + 10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy_c11", {31'b0, bus.busy}, 32'd0);
    check("flush result_held", bus.result, prev);
    check("flush start_cycle", cyc, n0 + 11);
    issue(ALU_MUL, 32'hDEADBEEF, 32'h1234567, 1'b1, "mul_after_flush");
    wait_idle("mul_after_flush");

    // Reset in cycle 20 of a DIV
    n0 = cyc;
    issue(ALU_DIV, 32'h7FFFFFFF, 32'd3, 1'b0, "div_reset");
    while (cyc < n0 + 20) @(negedge clk);
    reset = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    check("midreset busy", {31'b0, bus.busy}, 32'd0);
    check("midreset done", {31'b0, bus.done}, 32'd0);
    check("midreset result", bus.result, 32'd0);
    reset = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);

    // Randomized operations
    for (int i = 0; i < 150; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = mops[$urandom_range(0, 7)];
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, 1'b1, $sformatf("rand%0d_op%0d_%h_%h", i, op, a, b));
      wait_idle("rand");
    end

    wait_idle("final");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. Takes the decoded `alucode` and both operands when `start` is pulsed, computes over multiple cycles with one shared 64-bit shift datapath, and returns a 32-bit result with a one-cycle `done` pulse. `busy` feeds the pipeline hazard controller, which holds fetch/decode and bubbles execute while the unit works. `flush` from branch resolution aborts an in-flight operation.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `alucode` input 5: operation select; `MUL`, `MULH`, `MULHSU`, `MULHU`, `DIV`, `DIVU`, `REM`, `REMU` from the shared define file.
- `op1` input 32: rs1 value (multiplicand/dividend).
- `op2` input 32: rs2 value (multiplier/divisor).
- `flush` input 1: abort the current operation.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: single-cycle pulse; `result` valid in that cycle.
- `result` output 32: last completed result, held until the next completion.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE: if `start`, `alucode` is an M-op and `flush` is low, latch operands and op, compute operand magnitudes and result sign, clear the iteration counter (6 bits), and go to ITER. If the op is a divide special case, go to DONE directly. A `start` with a non-M `alucode` is ignored.
- Signedness: MUL/MULH/DIV/REM signed×signed; MULHSU op1 signed, op2 unsigned; MULHU/DIVU/REMU unsigned. Magnitudes use two's-complement negation; 0x80000000 maps to magnitude 2^31 (33-bit internal width, no overflow).
- Multiply: shift-add, one multiplier bit per cycle, 32 ITER cycles, 64-bit unsigned product. Product sign = sign(op1)^sign(op2) for signed operands.
- Divide: restoring, one quotient bit per cycle, 32 ITER cycles. Quotient sign = sign(op1)^sign(op2); remainder sign = sign(op1).
- FIX: apply sign negation (64-bit for multiply). Select the low word for MUL, the high word for MULH/MULHSU/MULHU, the quotient for DIV/DIVU, and the remainder for REM/REMU. Write `result`.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Special cases, decided in IDLE, skip ITER and FIX:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- Flush: in any non-IDLE state, go to IDLE at the next edge. No `done`; `result` is unchanged. If `flush` and `start` arrive together in IDLE, the start is dropped.
- `start` while busy is ignored; there is no queueing.

## Timing
- Cycle 0 is the cycle in which `start` is sampled.
- Normal op: ITER in cycles 1–32, FIX in cycle 33, DONE in cycle 34 (`done`=1, `result` valid). `busy` is high in cycles 1–34. IDLE in cycle 35; a new `start` is accepted in cycle 35.
- Special case: DONE in cycle 1; `busy` is high in cycle 1 only.
- `result` is registered and changes only on the edge entering DONE.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0. Reset mid-operation aborts without `done`, and `reset` overrides `flush` and `start`.
- No combinational path from inputs to `busy`/`done`/`result`. The hazard controller sees `busy` one cycle after `start`; the stall for cycle 0 itself is the controller's responsibility.

## Structure
- Shared define file (`99_define.vh`): the M-op `alucode` constants, the `MULSTALL`/`DIVSTALL` cycle counts (set to 34 here), and the state encodings.
- One sub-module: `div_restoring_step`, a combinational single iteration taking partial remainder, divisor and next dividend bit, and returning the new remainder and quotient bit. Instantiated once; multiply uses an inline adder.
- The hazard controller is updated to stall on `busy` instead of its internal counter. That change is tracked separately.

## Test plan
- MUL op1=7, op2=0xFFFFFFFD (−3) → cycle 34 `done`=1, `result`=0xFFFFFFEB; `busy` high in cycles 1–34.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → `done` in cycle 1, result 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same → 0.
- MUL started, `flush` in cycle 10 → `busy`=0 in cycle 11, no `done`, `result` keeps its previous value. A `start` in cycle 11 completes normally in cycle 45.
- `reset` in cycle 20 of a DIV → all outputs 0 next cycle. `start` with `alucode`=ADD → stays IDLE, `busy` stays 0.
